// File: rtl/mem_responder.sv
// Word-addressed memory slave with a fixed access latency, answering cache read/write
// requests and broadcasting completed atomic writes to the other caches.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_read,
  input  logic              ram_write,
  input  logic [DATA_W-1:0] ram_data_w,
  input  logic              cache_atomic_i,
  output logic              ram_wait,
  output logic [DATA_W-1:0] ram_data_r,
  output logic              atomic_bcast,
  output logic [ADDR_W-1:0] bcast_addr,
  output logic [DATA_W-1:0] bcast_data,
  output logic              req_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept, finish;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              atomic_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] bc_addr_q;
  logic [DATA_W-1:0] bc_data_q;
  logic              req_err_q;

  logic [DATA_W-1:0] mem [0:(2**MEM_AW)-1];
  logic [MEM_AW-1:0] idx;

  assign idx = addr_q[MEM_AW-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ram_wait = 1'b0;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ram_read || ram_write) begin
          ram_wait = 1'b1;
          accept   = 1'b1;
          cnt_d    = LAT_M1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        ram_wait = 1'b1;
        if (cnt_q == 4'd0) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      atomic_q  <= 1'b0;
      rdata_q   <= '0;
      bc_addr_q <= '0;
      bc_data_q <= '0;
      req_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q   <= ram_addr;
        wdata_q  <= ram_data_w;
        // A simultaneous read+write is served as a write.
        write_q  <= ram_write;
        atomic_q <= cache_atomic_i;
        if (ram_read && ram_write) req_err_q <= 1'b1;
      end
      if (finish && !write_q) rdata_q <= mem[idx];
      if (finish && write_q && atomic_q) begin
        bc_addr_q <= addr_q;
        bc_data_q <= wdata_q;
      end
    end
  end

  // No reset on the array; an abort via reset leaves state_q in IDLE so finish never fires.
  always_ff @(posedge clk) begin
    if (finish && write_q) mem[idx] <= wdata_q;
  end

  assign ram_data_r   = rdata_q;
  assign atomic_bcast = (state_q == DONE) && write_q && atomic_q;
  assign bcast_addr   = bc_addr_q;
  assign bcast_data   = bc_data_q;
  assign req_err      = req_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against an associative-array memory model.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ram_addr;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_data_w;
  logic        cache_atomic_i;
  logic        ram_wait;
  logic [31:0] ram_data_r;
  logic        atomic_bcast;
  logic [31:0] bcast_addr;
  logic [31:0] bcast_data;
  logic        req_err;

  mem_responder #(.DATA_W(32), .ADDR_W(32), .MEM_AW(12), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .ram_addr(ram_addr), .ram_read(ram_read),
    .ram_write(ram_write), .ram_data_w(ram_data_w), .cache_atomic_i(cache_atomic_i),
    .ram_wait(ram_wait), .ram_data_r(ram_data_r), .atomic_bcast(atomic_bcast),
    .bcast_addr(bcast_addr), .bcast_data(bcast_data), .req_err(req_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memory contents by word index, plus expected sticky/held outputs.
  logic [31:0] mem_m [int];
  logic [31:0] rd_exp    = '0;
  bit          rd_known  = 1'b1;
  logic [31:0] bc_addr_exp = '0;
  logic [31:0] bc_data_exp = '0;
  logic        err_exp   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int key_of(input logic [31:0] a);
    return int'(a & 32'h0000_0FFF);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic atom, input logic scramble);
    int  waits;
    int  i;
    bit  done;
    ram_read = rd; ram_write = wr; ram_addr = addr; ram_data_w = data; cache_atomic_i = atom;
    waits = 0; i = 0; done = 1'b0;
    #1;
    while (!done && i < 40) begin
      if (!ram_wait) begin
        done = 1'b1;
      end else begin
        waits++;
        if (i == 1 && scramble) begin
          ram_read = 1'b0; ram_write = 1'b0;
          ram_addr = $urandom; ram_data_w = $urandom; cache_atomic_i = 1'($urandom);
        end
        @(negedge clk);
      end
      i++;
    end
    check_eq("wait_cycles", 64'(waits), 64'(LAT + 1));
    if (wr) begin
      mem_m[key_of(addr)] = data;
      if (atom) begin
        bc_addr_exp = addr;
        bc_data_exp = data;
      end
      if (rd) err_exp = 1'b1;
    end else if (mem_m.exists(key_of(addr))) begin
      rd_exp = mem_m[key_of(addr)];
      rd_known = 1'b1;
    end else begin
      rd_known = 1'b0;
    end
    if (done) begin
      if (rd_known) check_eq("ram_data_r", 64'(ram_data_r), 64'(rd_exp));
      check_eq("atomic_bcast_done", 64'(atomic_bcast), 64'(wr && atom));
      check_eq("bcast_addr", 64'(bcast_addr), 64'(bc_addr_exp));
      check_eq("bcast_data", 64'(bcast_data), 64'(bc_data_exp));
      check_eq("req_err", 64'(req_err), 64'(err_exp));
    end
    $display("[TB] txn rd=%0d wr=%0d atom=%0d scr=%0d addr=0x%08h data=0x%08h rdata=0x%08h waits=%0d",
             rd, wr, atom, scramble, addr, data, ram_data_r, waits);
    ram_read = 1'b0; ram_write = 1'b0; cache_atomic_i = 1'b0;
    @(negedge clk);
    check_eq("idle_wait_low", 64'(ram_wait), 64'd0);
    check_eq("bcast_one_cycle", 64'(atomic_bcast), 64'd0);
  endtask

  initial begin
    int          k;
    int          c;
    int          first_done;
    int          last_done;
    int          prev_done;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  op;

    reset_n = 1'b0; ram_addr = '0; ram_read = 1'b0; ram_write = 1'b0;
    ram_data_w = '0; cache_atomic_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ram_wait", 64'(ram_wait), 64'd0);
    check_eq("rst_ram_data_r", 64'(ram_data_r), 64'd0);
    check_eq("rst_bcast", 64'({atomic_bcast, bcast_addr, bcast_data}), 64'd0);
    check_eq("rst_req_err", 64'(req_err), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic write then read-back.
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

    // Atomic write broadcasts; non-atomic write leaves broadcast regs alone.
    do_req(1'b0, 1'b1, 32'h0000_1234, 32'h5, 1'b1, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_0040, 32'h66, 1'b0, 1'b0);

    // Aliasing of upper address bits.
    do_req(1'b0, 1'b1, 32'h1004, 32'hA, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 32'h0004, 32'h0, 1'b0, 1'b0);

    // Read and write together: served as write, sticky error.
    do_req(1'b1, 1'b1, 32'h8, 32'h77, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);

    // Streaming reads with read held high and address stepped at each completion.
    for (int j = 0; j < 16; j++) do_req(1'b0, 1'b1, 32'h20 + 32'(j), $urandom, 1'b0, 1'b0);
    k = 0; c = 0; first_done = -1; last_done = -1; prev_done = -1;
    ram_read = 1'b1; ram_addr = 32'h20;
    #1;
    while (k < 16 && c < 120) begin
      if (!ram_wait) begin
        check_eq("stream_data", 64'(ram_data_r), 64'(mem_m[key_of(32'h20 + 32'(k))]));
        if (prev_done >= 0) check_eq("stream_period", 64'(c - prev_done), 64'(LAT + 2));
        if (first_done < 0) first_done = c;
        prev_done = c;
        last_done = c;
        $display("[TB] stream word %0d addr=0x%08h rdata=0x%08h cycle=%0d",
                 k, 32'h20 + 32'(k), ram_data_r, c);
        k++;
        if (k == 16) ram_read = 1'b0;
        else ram_addr = 32'h20 + 32'(k);
      end
      if (k < 16) @(negedge clk);
      c++;
    end
    ram_read = 1'b0;
    rd_exp = mem_m[key_of(32'h2F)];
    rd_known = 1'b1;
    check_eq("stream_count", 64'(k), 64'd16);
    check_eq("stream_first", 64'(first_done), 64'(LAT + 1));
    check_eq("stream_span", 64'(last_done + 1), 64'(16 * (LAT + 2)));
    @(negedge clk);

    // Randomized traffic over a small window, with random upper bits and in-flight input noise.
    for (int j = 0; j < 16; j++)
      do_req(1'b0, 1'b1, 32'h100 + 32'(j), $urandom, 1'($urandom), 1'b0);
    for (int j = 0; j < 40; j++) begin
      a  = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 15)));
      d  = $urandom;
      op = 2'($urandom_range(0, 2));
      do_req(op != 2'd1, op != 2'd0, a, d, 1'($urandom), 1'($urandom));
    end

    // Reset in the second ACCESS cycle of an atomic write aborts it.
    do_req(1'b0, 1'b1, 32'h3, 32'h11, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
    ram_write = 1'b1; ram_addr = 32'h3; ram_data_w = 32'h99; cache_atomic_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    ram_write = 1'b0; cache_atomic_i = 1'b0;
    #1;
    check_eq("abort_ram_wait", 64'(ram_wait), 64'd0);
    check_eq("abort_ram_data_r", 64'(ram_data_r), 64'd0);
    check_eq("abort_bcast", 64'({atomic_bcast, bcast_addr, bcast_data}), 64'd0);
    check_eq("abort_req_err", 64'(req_err), 64'd0);
    $display("[TB] reset asserted during ACCESS of write 0x99 to 0x3");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd_exp = '0; rd_known = 1'b1; bc_addr_exp = '0; bc_data_exp = '0; err_exp = 1'b0;
    @(negedge clk);
    do_req(1'b1, 1'b0, 32'h3, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
